// File: rtl/demodulator.sv
// DCSK receive path: delayed-chaos despread, per-bit majority vote, MSB-first deserialiser.
// Optional DEMOD_ERR_CNT_EN adds err_cnt: the number of chips per frame that disagreed with their bit's vote.
module demodulator #(
  parameter int MSG_WIDTH = 8,
  parameter int DELAY     = 2,
  parameter int SPREAD    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 rx_bit,
  input  logic                 chaos_bit,
  output logic [MSG_WIDTH-1:0] message,
  output logic                 msg_valid,
  output logic                 busy
`ifdef DEMOD_ERR_CNT_EN
  , output logic [$clog2(MSG_WIDTH*SPREAD+1)-1:0] err_cnt
`endif
);

  localparam int OW = $clog2(SPREAD + 1);
  localparam int CW = (SPREAD > 1) ? $clog2(SPREAD) : 1;
  localparam int BW = $clog2(MSG_WIDTH);
  localparam int SW = MSG_WIDTH - 1;

  localparam logic [CW-1:0] CHIP_LAST = CW'(SPREAD - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(MSG_WIDTH - 1);
  localparam logic [OW-1:0] HALF      = OW'(SPREAD / 2);
  localparam logic [OW-1:0] SPREAD_W  = OW'(SPREAD);

  localparam logic [0:0] IDLE    = 1'b0;
  localparam logic [0:0] COLLECT = 1'b1;

  generate
    if ((SPREAD < 1) || (SPREAD % 2 == 0)) begin : g_bad_spread
      $error("demodulator: SPREAD must be odd and >= 1");
    end
    if (MSG_WIDTH < 2) begin : g_bad_width
      $error("demodulator: MSG_WIDTH must be >= 2");
    end
    if (DELAY < 1) begin : g_bad_delay
      $error("demodulator: DELAY must be >= 1");
    end
  endgenerate

  logic [0:0]       state;
  logic [DELAY-1:0] dly;
  logic [OW-1:0]    ones_cnt;
  logic [CW-1:0]    chip_cnt;
  logic [BW-1:0]    bit_cnt;
  logic [SW-1:0]    shreg;

  logic          d;
  logic          frame_done;
  logic          take;
  logic          bit_end;
  logic [OW-1:0] old_ones;
  logic          old_bit;
  logic [OW-1:0] base_ones;
  logic [CW-1:0] base_chip;
  logic [BW-1:0] base_bitc;
  logic [SW-1:0] base_sh;
  logic [OW-1:0] new_ones;
  logic          new_bit;

  // The final chip of a frame closes it with the running counters; a coincident start
  // reuses that same chip as chip 0 of the next frame from zeroed counters.
  always_comb begin
    d          = rx_bit ^ dly[DELAY-1];
    old_ones   = ones_cnt + OW'(d);
    old_bit    = old_ones > HALF;
    frame_done = (state == COLLECT) && (chip_cnt == CHIP_LAST) && (bit_cnt == BIT_LAST);
    take       = start || ((state == COLLECT) && !frame_done);
    base_ones  = start ? '0 : ones_cnt;
    base_chip  = start ? '0 : chip_cnt;
    base_bitc  = start ? '0 : bit_cnt;
    base_sh    = start ? '0 : shreg;
    new_ones   = base_ones + OW'(d);
    new_bit    = new_ones > HALF;
    bit_end    = base_chip == CHIP_LAST;
  end

  assign busy = (state == COLLECT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      dly       <= '0;
      ones_cnt  <= '0;
      chip_cnt  <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      message   <= '0;
      msg_valid <= 1'b0;
    end else begin
      dly       <= DELAY'({dly, chaos_bit});
      msg_valid <= frame_done;
      if (frame_done) message <= {shreg, old_bit};
      if (take) begin
        state <= COLLECT;
        if (bit_end) begin
          shreg    <= SW'({base_sh, new_bit});
          ones_cnt <= '0;
          chip_cnt <= '0;
          bit_cnt  <= base_bitc + BW'(1);
        end else begin
          shreg    <= base_sh;
          ones_cnt <= new_ones;
          chip_cnt <= base_chip + CW'(1);
          bit_cnt  <= base_bitc;
        end
      end else if (frame_done) begin
        state    <= IDLE;
        ones_cnt <= '0;
        chip_cnt <= '0;
        bit_cnt  <= '0;
        shreg    <= '0;
      end
    end
  end

`ifdef DEMOD_ERR_CNT_EN
  localparam int EW = $clog2(MSG_WIDTH*SPREAD + 1);

  logic [EW-1:0] err_acc;
  logic [EW-1:0] base_err;
  logic [OW-1:0] old_dis;
  logic [OW-1:0] new_dis;

  // Minority chips of a bit are exactly its disagreements with the vote.
  always_comb begin
    old_dis  = old_bit ? (SPREAD_W - old_ones) : old_ones;
    new_dis  = new_bit ? (SPREAD_W - new_ones) : new_ones;
    base_err = start ? '0 : err_acc;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_acc <= '0;
      err_cnt <= '0;
    end else begin
      if (frame_done) err_cnt <= err_acc + EW'(old_dis);
      if (take) begin
        err_acc <= bit_end ? (base_err + EW'(new_dis)) : base_err;
      end else if (frame_done) begin
        err_acc <= '0;
      end
    end
  end
`else
  logic unused_spread_w;
  assign unused_spread_w = ^SPREAD_W;
`endif

endmodule
